// File: rtl/i2s_tx_if.sv
// I2S transmitter bus: configuration, FIFO write port, FIFO status and serial outputs.
// The slave modport is the transmitter side; the master modport is the host side.
interface i2s_tx_if;
  logic        en;
  logic [7:0]  sck_prescaler;
  logic [4:0]  sample_size;
  logic        left_justified;
  logic [1:0]  channels;
  logic        fifo_wr;
  logic [31:0] fifo_wdata;
  logic [4:0]  fifo_level_threshold;
  logic        fifo_full;
  logic        fifo_empty;
  logic [4:0]  fifo_level;
  logic        fifo_level_below;
  logic        sck;
  logic        ws;
  logic        sdo;
  logic        underrun;

  modport slave (
    input  en, sck_prescaler, sample_size, left_justified, channels,
           fifo_wr, fifo_wdata, fifo_level_threshold,
    output fifo_full, fifo_empty, fifo_level, fifo_level_below,
           sck, ws, sdo, underrun
  );

  modport master (
    output en, sck_prescaler, sample_size, left_justified, channels,
           fifo_wr, fifo_wdata, fifo_level_threshold,
    input  fifo_full, fifo_empty, fifo_level, fifo_level_below,
           sck, ws, sdo, underrun
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: 16x32 sample FIFO, programmable sck generator, 64-sck frame
// engine with left-justified or Philips output framing.
// Optional build macro I2S_TX_UNDERRUN_REPEAT_EN: an underrun slot repeats the
// last word popped for that channel instead of sending zeros.
module i2s_tx (
  input  logic       clk,
  input  logic       rst_n,
  i2s_tx_if.slave    bus
);

  logic [31:0] r_mem [0:15];
  logic [3:0]  r_wr_ptr;
  logic [3:0]  r_rd_ptr;
  logic [4:0]  r_count;
  logic [7:0]  r_presc;
  logic        r_sck;
  logic        r_ws;
  logic [4:0]  r_bit_ctr;
  logic [31:0] r_shift;
  logic        r_lj;        // current bit of the left-justified stream
  logic        r_lj_mode;   // framing latched at the last slot start
  logic        r_sdo;
  logic        r_underrun;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [31:0] r_last_l;
  logic [31:0] r_last_r;
`endif

  logic        w_full;
  logic        w_empty;
  logic        w_tick;
  logic        w_fe;
  logic        w_slot_start;
  logic        w_new_ws;
  logic        w_chan_en;
  logic        w_pop;
  logic        w_push;
  logic        w_underrun;
  logic [31:0] w_head;
  logic [31:0] w_load;
  logic        w_mode;
  logic        w_lj_next;
  logic        w_sdo_next;

  // Place the low N bits of a sample at the top of the slot word (N = 0 means 32).
  function automatic logic [31:0] align_sample(input logic [31:0] data, input logic [4:0] size);
    logic [5:0] n;
    n = (size == 5'd0) ? 6'd32 : {1'b0, size};
    return data << (6'd32 - n);
  endfunction

  assign w_full       = (r_count == 5'd16);
  assign w_empty      = (r_count == 5'd0);
  assign w_tick       = bus.en && (r_presc == 8'd0);
  assign w_fe         = w_tick && r_sck;
  assign w_slot_start = w_fe && (r_bit_ctr == 5'd31);
  assign w_new_ws     = ~r_ws;
  // ws=0 is the left slot (channels[1]), ws=1 the right slot (channels[0])
  assign w_chan_en    = w_new_ws ? bus.channels[0] : bus.channels[1];
  assign w_pop        = w_slot_start && w_chan_en && !w_empty;
  assign w_underrun   = w_slot_start && w_chan_en && w_empty;
  assign w_push       = bus.fifo_wr && !w_full;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_mode       = w_slot_start ? bus.left_justified : r_lj_mode;
  assign w_lj_next    = w_slot_start ? w_load[31] : r_shift[31];
  // Philips framing re-emits the previous left-justified bit, a one-FE delay
  assign w_sdo_next   = w_mode ? w_lj_next : r_lj;

  // Select the word loaded into the shift register at a slot start.
  always_comb begin
    w_load = 32'd0;
    if (w_pop) begin
      w_load = align_sample(w_head, bus.sample_size);
    end else if (w_underrun) begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      w_load = align_sample(w_new_ws ? r_last_r : r_last_l, bus.sample_size);
`else
      w_load = 32'd0;
`endif
    end else begin
      w_load = 32'd0;
    end
  end

  // FIFO storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.fifo_wdata;
    end
  end

  // FIFO pointers and occupancy; a push and pop in the same cycle leave the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 4'd0;
      r_rd_ptr <= 4'd0;
      r_count  <= 5'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 4'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 4'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serial clock generator and frame engine; everything outside underrun freezes while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= 8'd0;
      r_sck      <= 1'b0;
      r_ws       <= 1'b1;
      r_bit_ctr  <= 5'd31;
      r_shift    <= 32'd0;
      r_lj       <= 1'b0;
      r_lj_mode  <= 1'b0;
      r_sdo      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun;
      if (bus.en) begin
        if (r_presc == 8'd0) begin
          r_presc <= bus.sck_prescaler;
        end else begin
          r_presc <= r_presc - 8'd1;
        end
      end
      if (w_tick) begin
        r_sck <= ~r_sck;
      end
      if (w_fe) begin
        r_bit_ctr <= r_bit_ctr + 5'd1;
        r_lj      <= w_lj_next;
        r_sdo     <= w_sdo_next;
        if (w_slot_start) begin
          r_ws      <= w_new_ws;
          r_lj_mode <= bus.left_justified;
          r_shift   <= {w_load[30:0], 1'b0};
        end else begin
          r_shift   <= {r_shift[30:0], 1'b0};
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  // Remember the last word popped per channel for underrun repetition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_l <= 32'd0;
      r_last_r <= 32'd0;
    end else if (w_pop) begin
      if (w_new_ws) begin
        r_last_r <= w_head;
      end else begin
        r_last_l <= w_head;
      end
    end
  end
`endif

  assign bus.fifo_full        = w_full;
  assign bus.fifo_empty       = w_empty;
  assign bus.fifo_level       = r_count;
  assign bus.fifo_level_below = (r_count < bus.fifo_level_threshold);
  assign bus.sck              = r_sck;
  assign bus.ws               = r_ws;
  assign bus.sdo              = r_sdo;
  assign bus.underrun         = r_underrun;

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 The block SHALL have these ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 The block SHALL have these ports: en  in  1  enable for the serial clock generator and the frame engine.
REQ-004 The block SHALL have these ports: sck_prescaler  in  8  sck half-period minus one, in clk cycles.
REQ-005 The block SHALL have these ports: sample_size  in  5  valid bits per sample; 0 means 32.
REQ-006 The block SHALL have these ports: left_justified  in  1  1 selects left-justified format, 0 selects Philips format.
REQ-007 The block SHALL have these ports: channels  in  2  bit1 enables the left slot, bit0 enables the right slot.
REQ-008 The block SHALL have these ports: fifo_wr  in  1  FIFO push strobe, one word per cycle.
REQ-009 The block SHALL have these ports: fifo_wdata  in  32  sample, right-aligned in bits [sample_size-1:0].
REQ-010 The block SHALL have these ports: fifo_level_threshold  in  5  threshold for fifo_level_below.
REQ-011 The block SHALL have these ports: fifo_full, fifo_empty  out  1 each  FIFO status.
REQ-012 The block SHALL have these ports: fifo_level  out  5  word count, 0..16.
REQ-013 The block SHALL have these ports: fifo_level_below  out  1  asserted when fifo_level < fifo_level_threshold.
REQ-014 The block SHALL have these ports: sck  out  1  serial clock; ws  out  1  word select (0 = left, 1 = right); sdo  out  1  serial data.
REQ-015 The block SHALL have these ports: underrun  out  1  one-cycle pulse when a slot needs a word and the FIFO is empty.

Function
REQ-016 The FIFO SHALL hold 16 words of 32 bits, first in first out; fifo_wr while full SHALL be dropped with no state change; a simultaneous push and internal pop SHALL keep the level unchanged.
REQ-017 While en=1, the prescaler SHALL reload sck_prescaler when it reaches 0 and otherwise decrement, so each sck half-period is sck_prescaler+1 clk cycles.
REQ-018 sck SHALL toggle when en=1 and the prescaler is 0; a falling event (FE) is that condition with sck=1.
REQ-019 A 5-bit bit_ctr SHALL increment on each FE and wrap 31->0, giving 32 sck periods per slot and 64 per frame.
REQ-020 ws SHALL toggle on an FE where bit_ctr=31; that FE is the slot start.
REQ-021 At slot start, if the new slot's channel bit is set and the FIFO is non-empty, the block SHALL pop one word and load it into the 32-bit shift register as fifo_wdata[N-1:0] followed by 32-N zeros, where N is the effective sample_size.
REQ-022 At slot start, if the channel bit is set and the FIFO is empty, the block SHALL load zeros (see REQ-031) and pulse underrun for one clk cycle.
REQ-023 At slot start, if the channel bit is clear, the block SHALL load zeros, perform no pop and not pulse underrun.
REQ-024 In left-justified mode, sdo SHALL show the MSB on the slot-start FE and the next bit on each later FE.
REQ-025 In Philips mode, sdo SHALL be the left-justified bit stream delayed by exactly one FE, so the MSB appears one sck period after the ws edge.
REQ-026 sdo, ws and sck SHALL change only on clk edges; sdo and ws SHALL change only at FEs so they are stable at each sck rising edge.
REQ-027 While en=0, the prescaler, sck, ws, bit_ctr, the shift register and sdo SHALL hold their values, and FIFO pushes SHALL still be accepted.
REQ-028 A change to sample_size, left_justified or channels SHALL take effect at the next slot start.

Reset
REQ-029 On rst_n=0 the block SHALL immediately set: prescaler=0, sck=0, ws=1, bit_ctr=31, shift register=0, sdo=0, underrun=0, FIFO empty (fifo_empty=1, fifo_full=0, fifo_level=0).
REQ-030 Reset asserted mid-frame SHALL discard the current slot and all FIFO contents; after release with en=1, the first FE SHALL start a left slot.

Configuration
REQ-031 With macro I2S_TX_UNDERRUN_REPEAT_EN defined, an underrun slot SHALL retransmit the last word popped for that channel (0 if none since reset); without the macro it SHALL transmit zeros; underrun SHALL pulse in both builds.

Verification
REQ-032 Reset then en=1, sck_prescaler=1: sck period = 4 clk cycles, ws=0 after the first FE, ws toggles every 32 sck periods.
REQ-033 Left-justified, sample_size=16, channels=11, FIFO filled with 0x0000A5F0 then 0x00001234: left slot sdo = A5F0 MSB-first then 16 zeros, right slot = 1234 likewise.
REQ-034 Same data with left_justified=0: each slot's MSB appears on the second FE of the slot, and the last bit of the previous slot appears on the ws-edge FE.
REQ-035 channels=10 with 2 words pushed: only left slots pop, right slots send all zeros, fifo_level drops by 1 per frame, no underrun.
REQ-036 Push 17 words with en=0: fifo_full=1, fifo_level=16, the 17th word is dropped; with threshold=4, fifo_level_below=0.
REQ-037 Run with an empty FIFO: underrun pulses at each enabled slot start; sdo=0, or the last word when I2S_TX_UNDERRUN_REPEAT_EN is defined; rst_n pulsed mid-slot gives ws=1, sck=0, fifo_empty=1.
